dmem_port_arbiter: RTL and testbench

Shares the single read/write port of the data block RAM between the processor pipeline and one auxiliary requester, such as a bootloader or DMA engine. It sits between the X-stage memory request and the RAM primitive. The processor has fixed priority, and the auxiliary side uses a valid/ready handshake with a one-cycle read-return path. An optional starvation guard forces an auxiliary grant by stalling the processor for one cycle.

---
 rtl/dmem_port_arbiter_if.sv | 42 ++++
 rtl/dmem_port_arbiter.sv | 98 +++++++++
 tb/tb_dmem_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the X-stage request, the auxiliary requester and the data RAM port.
// slave = arbiter side, master = pipeline/aux/RAM side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic              cpu_stall;

  logic              aux_valid;
  logic              aux_ready;
  logic [3:0]        aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [31:0]       aux_din;
  logic              aux_rvalid;
  logic [31:0]       aux_rdata;

  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_stall,
    input  aux_valid, aux_we, aux_addr, aux_din,
    output aux_ready, aux_rvalid, aux_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_stall,
    output aux_valid, aux_we, aux_addr, aux_din,
    input  aux_ready, aux_rvalid, aux_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: CPU fixed priority, aux valid/ready with 0-cycle grant and 1-cycle read return.
// ARB_STARVE_EN adds the starvation guard that stalls the CPU for one cycle to force an aux grant.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gBadLimit
    $error("dmem_port_arbiter: STARVE_LIMIT out of range 1..255");
  end

  logic              cpuOwn;
  logic              auxOwn;
  logic              forceGrant;
  logic              rdPend;
  logic [31:0]       rdataQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       dinQ;

`ifdef ARB_STARVE_EN
  typedef enum logic {S_NORM, S_FORCE} state_t;

  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] starveCnt;
  logic [7:0] cntInc;

  assign cntInc = (starveCnt == 8'hFF) ? starveCnt : starveCnt + 8'd1;

  // Compare against the incremented count so the forced grant lands on denial LIMIT+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_NORM;
      starveCnt <= 8'd0;
    end else if (state == S_FORCE) begin
      state     <= S_NORM;
      starveCnt <= 8'd0;
    end else if (bus.aux_valid && bus.cpu_req) begin
      starveCnt <= cntInc;
      if (cntInc == LIMIT8)
        state <= S_FORCE;
    end else begin
      starveCnt <= 8'd0;
    end
  end

  assign forceGrant = (state == S_FORCE);
`else
  assign forceGrant = 1'b0;
`endif

  always_comb begin
    cpuOwn = 1'b0;
    auxOwn = 1'b0;
    if (!rst) begin
      if (forceGrant)
        auxOwn = bus.aux_valid;
      else if (bus.cpu_req)
        cpuOwn = 1'b1;
      else
        auxOwn = bus.aux_valid;
    end
  end

  assign bus.cpu_stall = forceGrant && !rst;
  assign bus.aux_ready = auxOwn;

  assign bus.ram_we   = cpuOwn ? bus.cpu_we   : (auxOwn ? bus.aux_we   : 4'b0000);
  assign bus.ram_addr = rst ? '0 : (cpuOwn ? bus.cpu_addr : (auxOwn ? bus.aux_addr : addrQ));
  assign bus.ram_din  = rst ? '0 : (cpuOwn ? bus.cpu_din  : (auxOwn ? bus.aux_din  : dinQ));

  assign bus.aux_rvalid = rdPend && !rst;
  assign bus.aux_rdata  = rst ? 32'd0 : (rdPend ? bus.ram_dout : rdataQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPend <= 1'b0;
      rdataQ <= 32'd0;
      addrQ  <= '0;
      dinQ   <= 32'd0;
    end else begin
      rdPend <= auxOwn && (bus.aux_we == 4'b0000);
      if (rdPend)
        rdataQ <= bus.ram_dout;
      // Idle cycles replay the last owner's address so the RAM sees no spurious change.
      if (cpuOwn || auxOwn) begin
        addrQ <= bus.ram_addr;
        dinQ  <= bus.ram_din;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a word-level memory and ownership reference model.
module tb_dmem_port_arbiter;
  localparam int AW    = 12;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW)) bus();

  dmem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram    [0:4095];
  logic [31:0] refMem [0:4095];

  always @(posedge clk) begin
    bus.ram_dout <= ram[bus.ram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
  end

  int errs   = 0;
  int checks = 0;

  bit          mForce;
  int          mStreak;
  bit          mPend;
  logic [31:0] mPendData;
  logic [31:0] mRdata;
  logic [31:0] mAddr;
  logic [31:0] mDin;
  int          forcedSeen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Called at posedge+1 with inputs already driven; checks outputs then advances to next posedge+1.
  task automatic cycle();
    bit          cpuOwn, auxOwn, frc;
    logic [3:0]  eWe;
    logic [31:0] eAddr, eDin;
    #2;
    if (rst) begin
      chk("stall_rst",  32'(bus.cpu_stall),  32'd0);
      chk("ready_rst",  32'(bus.aux_ready),  32'd0);
      chk("rvalid_rst", 32'(bus.aux_rvalid), 32'd0);
      chk("rdata_rst",  bus.aux_rdata,       32'd0);
      chk("we_rst",     32'(bus.ram_we),     32'd0);
      chk("addr_rst",   32'(bus.ram_addr),   32'd0);
      chk("din_rst",    bus.ram_din,         32'd0);
      mForce = 0; mStreak = 0; mPend = 0;
      mRdata = 0; mAddr = 0; mDin = 0;
    end else begin
      frc    = mForce;
      cpuOwn = !frc && bus.cpu_req;
      auxOwn = bus.aux_valid && (frc || !bus.cpu_req);
      if (cpuOwn) begin
        eWe = bus.cpu_we; eAddr = 32'(bus.cpu_addr); eDin = bus.cpu_din;
      end else if (auxOwn) begin
        eWe = bus.aux_we; eAddr = 32'(bus.aux_addr); eDin = bus.aux_din;
      end else begin
        eWe = 4'b0; eAddr = mAddr; eDin = mDin;
      end
      if (frc) forcedSeen++;
      chk("cpu_stall",  32'(bus.cpu_stall),  32'(frc));
      chk("aux_ready",  32'(bus.aux_ready),  32'(auxOwn));
      chk("aux_rvalid", 32'(bus.aux_rvalid), 32'(mPend));
      chk("aux_rdata",  bus.aux_rdata,       mPend ? mPendData : mRdata);
      chk("ram_we",     32'(bus.ram_we),     32'(eWe));
      chk("ram_addr",   32'(bus.ram_addr),   eAddr);
      chk("ram_din",    bus.ram_din,         eDin);

      if (mPend) mRdata = mPendData;
      if (auxOwn && bus.aux_we == 4'b0) mPendData = refMem[bus.aux_addr];
      mPend = auxOwn && (bus.aux_we == 4'b0);
      if (cpuOwn || auxOwn) begin
        refMem[eAddr[AW-1:0]] = merge(refMem[eAddr[AW-1:0]], eDin, eWe);
        mAddr = eAddr;
        mDin  = eDin;
      end
`ifdef ARB_STARVE_EN
      if (frc || !bus.aux_valid || auxOwn) begin
        mStreak = 0;
        mForce  = 0;
      end else begin
        mStreak = (mStreak < 255) ? mStreak + 1 : 255;
        mForce  = (mStreak == LIMIT);
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic contend(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 4'($urandom);
      bus.cpu_addr  = 12'($urandom_range(0, 15));
      bus.cpu_din   = $urandom;
      bus.aux_valid = 1'b1;
      bus.aux_we    = 4'($urandom_range(0, 1) * 15);
      bus.aux_addr  = 12'($urandom_range(0, 15));
      bus.aux_din   = $urandom;
      cycle();
    end
  endtask

  initial begin
    int f0;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = $urandom;
      refMem[i] = ram[i];
    end
    forcedSeen    = 0;
    rst           = 1'b1;
    bus.cpu_req   = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
    bus.aux_valid = 0; bus.aux_we = 0; bus.aux_addr = 0; bus.aux_din = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    bus.aux_valid = 1; bus.aux_we = 4'hF; bus.aux_addr = 12'h010; bus.aux_din = 32'hDEADBEEF;
    cycle();
    bus.aux_we = 4'h0; bus.aux_din = 0;
    cycle();
    bus.aux_valid = 0;
    cycle();
    chk("rdata_deadbeef", bus.aux_rdata, 32'hDEADBEEF);

`ifdef ARB_STARVE_EN
    f0 = forcedSeen;
    contend(36);
    chk("forced_in_36", 32'(forcedSeen - f0), 32'd4);
`else
    f0 = forcedSeen;
    contend(100);
    chk("forced_none", 32'(forcedSeen - f0), 32'd0);
`endif
    bus.cpu_req = 0; bus.aux_valid = 1;
    cycle();

    bus.cpu_req = 0; bus.aux_valid = 1; bus.aux_we = 0; bus.aux_addr = 12'h010;
    cycle();
    rst = 1; bus.aux_valid = 0;
    cycle();
    rst = 0;
    cycle();
    f0 = forcedSeen;
    contend(9);
`ifdef ARB_STARVE_EN
    chk("forced_after_rst", 32'(forcedSeen - f0), 32'd1);
`else
    chk("forced_after_rst", 32'(forcedSeen - f0), 32'd0);
`endif

    for (int i = 0; i < 2500; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.cpu_req   = ($urandom_range(0, 9) < 7);
      bus.cpu_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      bus.cpu_addr  = 12'($urandom_range(0, 15));
      bus.cpu_din   = $urandom;
      bus.aux_valid = ($urandom_range(0, 3) != 0);
      bus.aux_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      bus.aux_addr  = 12'($urandom_range(0, 15));
      bus.aux_din   = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
